// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// opcodes, ALU ops, branch types, datapath mux selects and instruction classes.
package ctrl_pkg;

    // FSM states (fixed 4-bit encoding kept for compatibility with older tooling)
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_EXEC_R   = 4'd3;
    localparam logic [3:0] ST_WB_R     = 4'd4;
    localparam logic [3:0] ST_EXEC_I   = 4'd5;
    localparam logic [3:0] ST_WB_I     = 4'd6;
    localparam logic [3:0] ST_MEM_ADDR = 4'd7;
    localparam logic [3:0] ST_MEM_RD   = 4'd8;
    localparam logic [3:0] ST_WB_MEM   = 4'd9;
    localparam logic [3:0] ST_MEM_WR   = 4'd10;
    localparam logic [3:0] ST_BRANCH   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;
    localparam logic [3:0] ST_JR       = 4'd13;
    localparam logic [3:0] ST_FAULT    = 4'd14;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BGEZ  = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FUNCT_JR = 6'd8;

    // ALU control ops
    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_BGEZ  = 3'b110;

    // Branch condition selects
    localparam logic [1:0] BR_BEQ  = 2'd0;
    localparam logic [1:0] BR_BGEZ = 2'd1;
    localparam logic [1:0] BR_BLT  = 2'd2;
    localparam logic [1:0] BR_BNE  = 2'd3;

    // Datapath mux selects
    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic       ALU_A_PC = 1'b0;
    localparam logic       ALU_A_RS = 1'b1;

    localparam logic [1:0] ALU_B_RT      = 2'd0;
    localparam logic [1:0] ALU_B_FOUR    = 2'd1;
    localparam logic [1:0] ALU_B_IMM     = 2'd2;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // Instruction classes produced by the opcode decoder
    typedef enum logic [2:0] {
        CLS_R,
        CLS_JR,
        CLS_I,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_e;

endpackage

// File: rtl/op_class_dec.sv
// Combinational opcode/funct classifier: instruction class plus the
// per-instruction ALU op, branch type and load/link flags.
module op_class_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output op_class_e  op_class,
    output logic [2:0] alu_op,
    output logic [1:0] branch_type,
    output logic       is_load,
    output logic       is_link,
    output logic       illegal
);

    // Classify the opcode; anything not listed is illegal
    always_comb begin
        op_class    = CLS_ILLEGAL;
        alu_op      = ALU_RTYPE;
        branch_type = BR_BEQ;
        is_load     = 1'b0;
        is_link     = 1'b0;
        case (op)
            OP_RTYPE: op_class = (funct == FUNCT_JR) ? CLS_JR : CLS_R;
            OP_ADDI: begin op_class = CLS_I; alu_op = ALU_ADD; end
            OP_SLTI: begin op_class = CLS_I; alu_op = ALU_SLT; end
            OP_ORI:  begin op_class = CLS_I; alu_op = ALU_OR;  end
            OP_LUI:  begin op_class = CLS_I; alu_op = ALU_LUI; end
            OP_LW:   begin op_class = CLS_MEM; alu_op = ALU_ADD; is_load = 1'b1; end
            OP_SW:   begin op_class = CLS_MEM; alu_op = ALU_ADD; end
            OP_BEQ:  begin op_class = CLS_BRANCH; alu_op = ALU_SUB;  branch_type = BR_BEQ;  end
            OP_BNE:  begin op_class = CLS_BRANCH; alu_op = ALU_SUB;  branch_type = BR_BNE;  end
            OP_BLT:  begin op_class = CLS_BRANCH; alu_op = ALU_SUB;  branch_type = BR_BLT;  end
            OP_BGEZ: begin op_class = CLS_BRANCH; alu_op = ALU_BGEZ; branch_type = BR_BGEZ; end
            OP_J:    op_class = CLS_JUMP;
            OP_JAL:  begin op_class = CLS_JUMP; is_link = 1'b1; end
            default: op_class = CLS_ILLEGAL;
        endcase
        illegal = (op_class == CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, handshakes with
// a variable-latency memory, faults on illegal opcodes or memory timeouts and
// counts retired instructions.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int CNT_W       = 32,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         instr_op_i,
    input  logic [5:0]         funct_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               iord_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_src_o,
    output logic [1:0]         branch_type_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               fault_o,
    output logic [CNT_W-1:0]   retire_cnt_o
);

    logic [3:0]       state_reg, state_next;
    logic [2:0]       alu_op_reg;
    logic [1:0]       branch_type_reg;
    logic             is_load_reg, is_link_reg;
    logic [TMO_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] retire_cnt_reg;

    op_class_e        dec_class;
    logic [2:0]       dec_alu_op;
    logic [1:0]       dec_branch_type;
    logic             dec_is_load, dec_is_link, dec_illegal;

    logic             mem_state, mem_timeout, retire_evt;
    logic [2:0]       alu_op_c;

    op_class_dec u_dec (
        .op          (instr_op_i),
        .funct       (funct_i),
        .op_class    (dec_class),
        .alu_op      (dec_alu_op),
        .branch_type (dec_branch_type),
        .is_load     (dec_is_load),
        .is_link     (dec_is_link),
        .illegal     (dec_illegal)
    );

    // A memory access may see MEM_TIMEOUT-1 not-ready cycles; the cycle that
    // would bring the count to the limit still completes if ready is high.
    assign mem_state   = (state_reg == ST_FETCH) || (state_reg == ST_MEM_RD) ||
                         (state_reg == ST_MEM_WR);
    assign mem_timeout = !mem_ready_i && (wait_cnt_reg == TMO_W'(MEM_TIMEOUT - 1));

    // Next-state selection
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     state_next = ST_FETCH;
            ST_FETCH:    if (mem_ready_i) state_next = ST_DECODE;
                         else if (mem_timeout) state_next = ST_FAULT;
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_next = ST_FAULT;
                end else begin
                    case (dec_class)
                        CLS_R:      state_next = ST_EXEC_R;
                        CLS_JR:     state_next = ST_JR;
                        CLS_I:      state_next = ST_EXEC_I;
                        CLS_MEM:    state_next = ST_MEM_ADDR;
                        CLS_BRANCH: state_next = ST_BRANCH;
                        CLS_JUMP:   state_next = ST_JUMP;
                        default:    state_next = ST_FAULT;
                    endcase
                end
            end
            ST_EXEC_R:   state_next = ST_WB_R;
            ST_EXEC_I:   state_next = ST_WB_I;
            ST_MEM_ADDR: state_next = is_load_reg ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready_i) state_next = ST_WB_MEM;
                         else if (mem_timeout) state_next = ST_FAULT;
            ST_MEM_WR:   if (mem_ready_i) state_next = ST_FETCH;
                         else if (mem_timeout) state_next = ST_FAULT;
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_JR:
                         state_next = ST_FETCH;
            ST_FAULT:    state_next = ST_FAULT;
            default:     state_next = ST_FAULT;
        endcase
    end

    // An instruction retires on the edge leaving its final state
    always_comb begin
        retire_evt = 1'b0;
        case (state_reg)
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_JR: retire_evt = 1'b1;
            ST_MEM_WR: retire_evt = mem_ready_i;
            default:   retire_evt = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Latch per-instruction attributes while the IR is being decoded
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_op_reg      <= ALU_RTYPE;
            branch_type_reg <= BR_BEQ;
            is_load_reg     <= 1'b0;
            is_link_reg     <= 1'b0;
        end else if (state_reg == ST_DECODE) begin
            alu_op_reg      <= dec_alu_op;
            branch_type_reg <= dec_branch_type;
            is_load_reg     <= dec_is_load;
            is_link_reg     <= dec_is_link;
        end
    end

    // Memory wait counter: restarts on every state change, counts not-ready cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          wait_cnt_reg <= '0;
        else if (state_next != state_reg)   wait_cnt_reg <= '0;
        else if (mem_state && !mem_ready_i) wait_cnt_reg <= wait_cnt_reg + TMO_W'(1);
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           retire_cnt_reg <= '0;
        else if (retire_evt) retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
    end

    // Per-state datapath controls
    always_comb begin
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        iord_o          = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = PC_SRC_PC4;
        branch_type_o   = BR_BEQ;
        alu_src_a_o     = ALU_A_PC;
        alu_src_b_o     = ALU_B_RT;
        alu_op_c        = ALU_RTYPE;
        reg_write_o     = 1'b0;
        reg_dst_o       = REG_DST_RT;
        mem_to_reg_o    = M2R_ALU;
        fault_o         = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = ALU_B_FOUR;
                alu_op_c    = ALU_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            ST_DECODE: begin
                alu_src_b_o = ALU_B_IMM_SH2;
                alu_op_c    = ALU_ADD;
            end
            ST_EXEC_R: begin
                alu_src_a_o = ALU_A_RS;
                alu_src_b_o = ALU_B_RT;
                alu_op_c    = ALU_RTYPE;
            end
            ST_WB_R: begin
                reg_dst_o   = REG_DST_RD;
                reg_write_o = 1'b1;
            end
            ST_EXEC_I: begin
                alu_src_a_o = ALU_A_RS;
                alu_src_b_o = ALU_B_IMM;
                alu_op_c    = alu_op_reg;
            end
            ST_WB_I: reg_write_o = 1'b1;
            ST_MEM_ADDR: begin
                alu_src_a_o = ALU_A_RS;
                alu_src_b_o = ALU_B_IMM;
                alu_op_c    = ALU_ADD;
            end
            ST_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            ST_WB_MEM: begin
                mem_to_reg_o = M2R_MDR;
                reg_write_o  = mem_ready_i;
            end
            ST_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o     = ALU_A_RS;
                alu_src_b_o     = ALU_B_RT;
                alu_op_c        = alu_op_reg;
                pc_write_cond_o = 1'b1;
                pc_src_o        = PC_SRC_BRANCH;
                branch_type_o   = branch_type_reg;
            end
            ST_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = PC_SRC_JUMP;
                if (is_link_reg) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = REG_DST_RA;
                    mem_to_reg_o = M2R_PC;
                end
            end
            ST_JR: begin
                pc_write_o = 1'b1;
                pc_src_o   = PC_SRC_RS;
            end
            ST_FAULT: fault_o = 1'b1;
            default: ;
        endcase
    end

    assign alu_op_o     = ALUOP_W'(alu_op_c);
    assign retire_cnt_o = retire_cnt_reg;

endmodule
